// File: rtl/ldpc_syndrome_gen_if.sv
// Key-bit input stream and syndrome-bit output stream of the LDPC syndrome generator.
interface ldpc_syndrome_gen_if;
    logic in_bit;
    logic in_valid;
    logic in_last;
    logic in_ready;
    logic out_bit;
    logic out_valid;
    logic out_last;
    logic out_ready;

    // Producer of key bits / consumer of syndrome bits
    modport master (
        output in_bit, in_valid, in_last, out_ready,
        input  in_ready, out_bit, out_valid, out_last
    );

    // The syndrome generator itself
    modport slave (
        input  in_bit, in_valid, in_last, out_ready,
        output in_ready, out_bit, out_valid, out_last
    );
endinterface

// File: rtl/ldpc_syndrome_gen.sv
// GF(2) syndrome generator: accumulates s = H*x over one n-bit key frame using the
// variable-node neighbour table, then streams the m syndrome bits out.
module ldpc_syndrome_gen #(
    parameter int unsigned N     = 204,
    parameter int unsigned M     = 102,
    parameter int unsigned LOG2N = 8,
    parameter int unsigned LOG2M = 7,
    parameter int unsigned DEG_V = 3
) (
    input  logic                         clk_i,
    input  logic                         rst_n_i,
    input  logic [N*DEG_V*LOG2M-1:0]     v_neighbor_i,
    ldpc_syndrome_gen_if.slave           bus,
    output logic                         done_o,
    output logic [LOG2M:0]               syn_weight_o,
    output logic                         frame_err_o,
    output logic                         cfg_err_o
);
    localparam int unsigned TBL_W  = N * DEG_V * LOG2M;
    localparam int unsigned TBL_IW = $clog2(TBL_W);
    localparam int unsigned WW     = LOG2M + 1;

    typedef enum logic {ACCUM = 1'b0, OUT = 1'b1} state_e;

    state_e             state_q;
    logic [M-1:0]       syn_q;
    logic [LOG2N-1:0]   var_cnt_q;
    logic [LOG2M-1:0]   chk_cnt_q;
    logic [WW-1:0]      wcnt_q;
    logic               in_ready_q;
    logic               out_valid_q;
    logic               out_bit_q;
    logic               out_last_q;
    logic               done_q;
    logic [WW-1:0]      syn_weight_q;
    logic               frame_err_q;
    logic               cfg_err_q;

    logic [M-1:0]       mask_c;
    logic [M-1:0]       syn_acc_c;
    logic               cfg_hit_c;
    logic [LOG2M-1:0]   idx_c;
    logic [TBL_IW-1:0]  base_c;
    logic               last_var_c;
    logic [LOG2M-1:0]   chk_nx_c;

    // Check mask of the current variable; duplicate entries cancel, out-of-range entries are flagged
    always_comb begin
        mask_c    = '0;
        cfg_hit_c = 1'b0;
        idx_c     = '0;
        base_c    = '0;
        for (int unsigned k = 0; k < DEG_V; k++) begin
            base_c = TBL_IW'((32'(var_cnt_q) * DEG_V + k) * LOG2M);
            idx_c  = v_neighbor_i[base_c +: LOG2M];
            if (32'(idx_c) < M) begin
                mask_c[idx_c] = ~mask_c[idx_c];
            end else begin
                cfg_hit_c = 1'b1;
            end
        end
        syn_acc_c  = bus.in_bit ? (syn_q ^ mask_c) : syn_q;
        last_var_c = (var_cnt_q == LOG2N'(N - 1));
        chk_nx_c   = chk_cnt_q + LOG2M'(1);
    end

    // Frame FSM: accumulate key bits, then stream syndrome bits with registered outputs
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q      <= ACCUM;
            syn_q        <= '0;
            var_cnt_q    <= '0;
            chk_cnt_q    <= '0;
            wcnt_q       <= '0;
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
            out_bit_q    <= 1'b0;
            out_last_q   <= 1'b0;
            done_q       <= 1'b0;
            syn_weight_q <= '0;
            frame_err_q  <= 1'b0;
            cfg_err_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ACCUM: begin
                    if (bus.in_valid) begin
                        syn_q <= syn_acc_c;
                        if (cfg_hit_c) begin
                            cfg_err_q <= 1'b1;
                        end
                        if (bus.in_last != last_var_c) begin
                            frame_err_q <= 1'b1;
                        end
                        if (last_var_c) begin
                            var_cnt_q   <= '0;
                            chk_cnt_q   <= '0;
                            wcnt_q      <= '0;
                            state_q     <= OUT;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                            out_bit_q   <= syn_acc_c[0];
                            out_last_q  <= (M == 1);
                        end else begin
                            var_cnt_q <= var_cnt_q + LOG2N'(1);
                        end
                    end
                end
                OUT: begin
                    if (bus.out_ready) begin
                        if (out_last_q) begin
                            syn_weight_q <= wcnt_q + WW'(out_bit_q);
                            done_q       <= 1'b1;
                            syn_q        <= '0;
                            state_q      <= ACCUM;
                            in_ready_q   <= 1'b1;
                            out_valid_q  <= 1'b0;
                            out_bit_q    <= 1'b0;
                            out_last_q   <= 1'b0;
                        end else begin
                            chk_cnt_q  <= chk_nx_c;
                            wcnt_q     <= wcnt_q + WW'(out_bit_q);
                            out_bit_q  <= syn_q[chk_nx_c];
                            out_last_q <= (chk_nx_c == LOG2M'(M - 1));
                        end
                    end
                end
                default: state_q <= ACCUM;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_bit   = out_bit_q;
    assign bus.out_last  = out_last_q;
    assign done_o        = done_q;
    assign syn_weight_o  = syn_weight_q;
    assign frame_err_o   = frame_err_q;
    assign cfg_err_o     = cfg_err_q;
endmodule

// File: tb/tb_ldpc_syndrome_gen.sv
// Self-checking bench for ldpc_syndrome_gen: frame-level model plus directed literal checks.
module tb_ldpc_syndrome_gen;
    localparam int N     = 204;
    localparam int M     = 102;
    localparam int LOG2M = 7;
    localparam int DEG_V = 3;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic [N*DEG_V*LOG2M-1:0] tbl;
    logic                     done;
    logic [LOG2M:0]           syn_weight;
    logic                     frame_err;
    logic                     cfg_err;

    ldpc_syndrome_gen_if bus();

    ldpc_syndrome_gen dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .v_neighbor_i (tbl),
        .bus          (bus.slave),
        .done_o       (done),
        .syn_weight_o (syn_weight),
        .frame_err_o  (frame_err),
        .cfg_err_o    (cfg_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int entry(input int j, input int k);
        return int'(tbl[(j*DEG_V+k)*LOG2M +: LOG2M]);
    endfunction

    task automatic set_var(input int j, input int e0, input int e1, input int e2);
        tbl[(j*DEG_V+0)*LOG2M +: LOG2M] = LOG2M'(e0);
        tbl[(j*DEG_V+1)*LOG2M +: LOG2M] = LOG2M'(e1);
        tbl[(j*DEG_V+2)*LOG2M +: LOG2M] = LOG2M'(e2);
    endtask

    // s = H*x over GF(2): every in-range neighbour of a 1-variable toggles its check
    function automatic logic [M-1:0] ref_syndrome(input logic [N-1:0] key);
        logic [M-1:0] s = '0;
        for (int j = 0; j < N; j++)
            for (int k = 0; k < DEG_V; k++)
                if (key[j] && entry(j, k) < M) s[entry(j, k)] = ~s[entry(j, k)];
        return s;
    endfunction

    // Frame-level model state
    bit           mon_en = 1'b0;
    bit           m_out, m_done, m_ferr, m_cerr;
    int           m_cnt, m_idx, frames_done;
    logic [N-1:0] m_key;
    logic [M-1:0] m_syn, cap_syn;
    int           m_weight;

    initial begin
        m_out = 0; m_done = 0; m_ferr = 0; m_cerr = 0;
        m_cnt = 0; m_idx = 0; frames_done = 0; m_weight = 0;
        m_key = '0; m_syn = '0; cap_syn = '0;
    end

    // Compare DUT against the model every cycle, then advance the model on this cycle's handshakes
    always @(negedge clk) begin
        if (mon_en) begin
            chk("in_ready",   bus.in_ready,  !m_out);
            chk("out_valid",  bus.out_valid, m_out);
            chk("done",       done,          m_done);
            chk("syn_weight", syn_weight,    128'(m_weight));
            chk("frame_err",  frame_err,     m_ferr);
            chk("cfg_err",    cfg_err,       m_cerr);
            if (m_out) begin
                chk("out_bit",  bus.out_bit,  m_syn[m_idx]);
                chk("out_last", bus.out_last, m_idx == M-1);
            end
        end
        if (!rst_n) begin
            m_out = 0; m_done = 0; m_ferr = 0; m_cerr = 0;
            m_cnt = 0; m_idx = 0; m_weight = 0;
        end else begin
            m_done = 0;
            if (!m_out && bus.in_valid) begin
                m_key[m_cnt] = bus.in_bit;
                if (bus.in_last != (m_cnt == N-1)) m_ferr = 1;
                for (int k = 0; k < DEG_V; k++)
                    if (entry(m_cnt, k) >= M) m_cerr = 1;
                if (m_cnt == N-1) begin
                    m_syn = ref_syndrome(m_key);
                    m_out = 1; m_idx = 0; m_cnt = 0;
                end else begin
                    m_cnt++;
                end
            end else if (m_out && bus.out_ready) begin
                cap_syn[m_idx] = bus.out_bit;
                if (m_idx == M-1) begin
                    m_out = 0; m_done = 1;
                    m_weight = $countones(m_syn);
                    frames_done++;
                end else begin
                    m_idx++;
                end
            end
        end
    end

    task automatic reset_begin();
        rst_n = 1'b0; bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.out_ready = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic reset_end();
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    // Send the first nbits of a frame, optionally with idle gaps between bits
    task automatic send_bits(input logic [N-1:0] key, input int nbits, input bit gaps, input int last_pos);
        bit ok;
        int guard;
        for (int i = 0; i < nbits; i++) begin
            if (gaps) begin
                bus.in_valid = 1'b0;
                repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            end
            bus.in_valid = 1'b1;
            bus.in_bit   = key[i];
            bus.in_last  = (i == last_pos);
            guard = 0;
            do begin
                ok = bus.in_ready;
                @(posedge clk); #1;
                guard++;
            end while (!ok && guard < 50);
            if (!ok) chk("in_accept_timeout", ok, 1'b1);
        end
        bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.in_bit = 1'b0;
    endtask

    // Drain the syndrome until the model sees the last accept
    task automatic drain(input int target, input bit rnd_rdy);
        int guard = 0;
        while (frames_done < target && guard < 2000) begin
            bus.out_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            @(posedge clk); #1;
            guard++;
        end
        bus.out_ready = 1'b0;
        chk("frame_timeout", frames_done >= target, 1'b1);
    endtask

    task automatic run_frame(input logic [N-1:0] key, input bit gaps, input int last_pos, input bit rnd_rdy);
        int target = frames_done + 1;
        send_bits(key, N, gaps, last_pos);
        chk("out_valid_latency", bus.out_valid, 1'b1);
        drain(target, rnd_rdy);
    endtask

    function automatic logic [N-1:0] rand_key();
        logic [N-1:0] k;
        for (int i = 0; i < N; i++) k[i] = 1'($urandom_range(0, 1));
        return k;
    endfunction

    logic [N-1:0] key;
    logic [M-1:0] lit;

    initial begin
        rst_n = 1'b0;
        bus.in_bit = 1'b0; bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.out_ready = 1'b0;
        for (int j = 0; j < N; j++)
            set_var(j, $urandom_range(0, M-1), $urandom_range(0, M-1), $urandom_range(0, M-1));
        set_var(5, 3, 17, 40);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        mon_en = 1'b1;

        // Reset values
        chk("rst_in_ready",   bus.in_ready,  1'b1);
        chk("rst_out_valid",  bus.out_valid, 1'b0);
        chk("rst_out_bit",    bus.out_bit,   1'b0);
        chk("rst_out_last",   bus.out_last,  1'b0);
        chk("rst_done",       done,          1'b0);
        chk("rst_syn_weight", syn_weight,    0);
        chk("rst_errors",     {frame_err, cfg_err}, 2'b00);

        // All-zero frame
        run_frame('0, 1'b0, N-1, 1'b0);
        chk("zero_syn",    cap_syn,    0);
        chk("zero_done",   done,       1'b1);
        chk("zero_weight", syn_weight, 0);
        chk("zero_errors", {frame_err, cfg_err}, 2'b00);

        // Single 1 at var 5 with checks {3,17,40}
        key = '0; key[5] = 1'b1;
        lit = '0; lit[3] = 1'b1; lit[17] = 1'b1; lit[40] = 1'b1;
        run_frame(key, 1'b0, N-1, 1'b0);
        chk("v5_model_syn", m_syn,      lit);
        chk("v5_dut_syn",   cap_syn,    lit);
        chk("v5_weight",    syn_weight, 3);

        // Duplicate entries cancel; out-of-range entries flag cfg_err only
        reset_begin();
        set_var(7, 9, 9, 20);
        set_var(8, 110, 110, 110);
        reset_end();
        key = '0; key[7] = 1'b1; key[8] = 1'b1;
        lit = '0; lit[20] = 1'b1;
        run_frame(key, 1'b0, N-1, 1'b0);
        chk("dup_model_syn", m_syn,      lit);
        chk("dup_dut_syn",   cap_syn,    lit);
        chk("dup_weight",    syn_weight, 1);
        chk("cfg_err_set",   cfg_err,    1'b1);
        reset_begin();
        set_var(8, $urandom_range(0, M-1), $urandom_range(0, M-1), $urandom_range(0, M-1));
        reset_end();
        chk("cfg_err_cleared", cfg_err, 1'b0);

        // Random keys with input gaps and output back-pressure
        repeat (2) begin
            key = rand_key();
            run_frame(key, 1'b1, N-1, 1'b1);
            chk("rand_dut_syn", cap_syn, ref_syndrome(key));
        end

        // Misplaced in_last: frame still ends by count
        key = rand_key();
        run_frame(key, 1'b0, 100, 1'b0);
        chk("frame_err_set", frame_err, 1'b1);
        chk("misframe_syn",  cap_syn,   ref_syndrome(key));

        // Reset mid-frame after 100 bits, then a single 1 at var 0
        reset_begin();
        set_var(0, 0, 50, 101);
        reset_end();
        send_bits(rand_key(), 100, 1'b0, N-1);
        reset_begin();
        reset_end();
        chk("mid_rst_errors",   {frame_err, cfg_err}, 2'b00);
        chk("mid_rst_in_ready", bus.in_ready, 1'b1);
        key = '0; key[0] = 1'b1;
        lit = '0; lit[0] = 1'b1; lit[50] = 1'b1; lit[101] = 1'b1;
        run_frame(key, 1'b0, N-1, 1'b0);
        chk("v0_dut_syn", cap_syn,    lit);
        chk("v0_weight",  syn_weight, 3);

        repeat (3) @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
